// File: rtl/abro_stim_driver.sv
// Stimulus driver for the ABRO state machine.
// Each accepted start runs one A/B pulse sequence against the ABRO instance,
// watches O for a response within a timeout, and keeps pass/fail tallies.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-low reset
//   start           - one-cycle command strobe, honoured only when idle
//   order           - 00 A,B / 01 B,A / 10 A+B together / 11 A only (expect no O)
//   gap             - idle cycles between first and second pulse
//   timeout         - maximum wait cycles for O (0 behaves as 1)
//   dut_rst, A, B   - stimulus to the ABRO instance
//   O_in            - ABRO output
//   busy, done      - run in progress / end-of-run strobe
//   pass, early     - run result, valid while done is high
//   pass_cnt        - saturating count of passed runs
//   fail_cnt        - saturating count of failed runs
module abro_stim_driver #(
    parameter int unsigned GAP_W = 8,
    parameter int unsigned TMO_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       order,
    input  logic [GAP_W-1:0] gap,
    input  logic [TMO_W-1:0] timeout,
    output logic             dut_rst,
    output logic             A,
    output logic             B,
    input  logic             O_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             early,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_DUT = 3'd1;
    localparam logic [2:0] S_FIRST   = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_SECOND  = 3'd4;
    localparam logic [2:0] S_WAIT_O  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] ORD_AB   = 2'b00;
    localparam logic [1:0] ORD_BA   = 2'b01;
    localparam logic [1:0] ORD_BOTH = 2'b10;
    localparam logic [1:0] ORD_A    = 2'b11;

    logic [2:0]       state_q,    state_d;
    logic [1:0]       order_q,    order_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic [GAP_W-1:0] gcnt_q,     gcnt_d;
    logic [TMO_W-1:0] tcnt_q,     tcnt_d;
    logic             resp_q,     resp_d;
    logic             dut_rst_q,  dut_rst_d;
    logic             a_q,        a_d;
    logic             b_q,        b_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic             early_q,    early_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [TMO_W-1:0] tmo_eff;

    // A zero timeout still allows one wait cycle.
    assign tmo_eff = (tmo_q == '0) ? TMO_W'(1) : tmo_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        gcnt_d     = gcnt_q;
        tcnt_d     = tcnt_q;
        resp_d     = resp_q;
        pass_d     = 1'b0;
        early_d    = 1'b0;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    order_d = order;
                    gap_d   = gap;
                    tmo_d   = timeout;
                    resp_d  = 1'b0;
                    state_d = S_RST_DUT;
                end
            end
            S_RST_DUT: begin
                state_d = S_FIRST;
            end
            S_FIRST: begin
                if (order_q == ORD_BOTH) begin
                    // Both inputs together complete the sequence here.
                    resp_d  = O_in;
                    tcnt_d  = tmo_eff;
                    state_d = S_WAIT_O;
                end else if (O_in) begin
                    early_d = 1'b1;
                    state_d = S_DONE;
                end else if (gap_q != '0) begin
                    gcnt_d  = gap_q;
                    state_d = S_GAP;
                end else begin
                    state_d = S_SECOND;
                end
            end
            S_GAP: begin
                if (O_in) begin
                    early_d = 1'b1;
                    state_d = S_DONE;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    state_d = S_SECOND;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            S_SECOND: begin
                resp_d  = O_in;
                tcnt_d  = tmo_eff;
                state_d = S_WAIT_O;
            end
            S_WAIT_O: begin
                // A response captured in the completing pulse ends the wait at once.
                if (resp_q || O_in) begin
                    pass_d  = (order_q != ORD_A);
                    state_d = S_DONE;
                end else if (tcnt_q <= TMO_W'(1)) begin
                    pass_d  = (order_q == ORD_A);
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q - TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Tallies move together with the done strobe.
        if (state_d == S_DONE) begin
            if (pass_d) begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
        end

        dut_rst_d = (state_d == S_RST_DUT);
        a_d       = ((state_d == S_FIRST)  && (order_d != ORD_BA)) ||
                    ((state_d == S_SECOND) && (order_d == ORD_BA));
        b_d       = ((state_d == S_FIRST)  && ((order_d == ORD_BA) || (order_d == ORD_BOTH))) ||
                    ((state_d == S_SECOND) && (order_d == ORD_AB));
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            order_q    <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            gcnt_q     <= '0;
            tcnt_q     <= '0;
            resp_q     <= 1'b0;
            dut_rst_q  <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            early_q    <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            order_q    <= order_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            gcnt_q     <= gcnt_d;
            tcnt_q     <= tcnt_d;
            resp_q     <= resp_d;
            dut_rst_q  <= dut_rst_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            early_q    <= early_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign dut_rst  = dut_rst_q;
    assign A        = a_q;
    assign B        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign early    = early_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_abro_stim_driver.sv
// Directed bench for abro_stim_driver (2-bit counters to reach saturation).
module tb_abro_stim_driver;

    localparam int unsigned GAP_W = 8;
    localparam int unsigned TMO_W = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       order;
    logic [GAP_W-1:0] gap;
    logic [TMO_W-1:0] timeout;
    logic             dut_rst, A, B, O_in, busy, done, pass, early;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    int total = 0;
    int bad   = 0;

    // Per-run capture: bit c set when the signal was high in cycle c.
    logic [31:0] rst_m, a_m, b_m, done_m, busy_m;
    logic        pass_v, early_v;

    abro_stim_driver #(.GAP_W(GAP_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .order(order), .gap(gap),
        .timeout(timeout), .dut_rst(dut_rst), .A(A), .B(B), .O_in(O_in),
        .busy(busy), .done(done), .pass(pass), .early(early),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one run cycle by cycle; cycle 0 is the cycle start may be high in.
    task automatic run(input logic [1:0] ord, input int g, input int t, input int o_cyc,
                       input logic [31:0] st_mask, input int rst_cyc, input int ncyc);
        rst_m = '0; a_m = '0; b_m = '0; done_m = '0; busy_m = '0;
        pass_v = 1'b0; early_v = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            order   = ord;
            gap     = GAP_W'(g);
            timeout = TMO_W'(t);
            start   = st_mask[c];
            O_in    = (c == o_cyc);
            reset   = (c == rst_cyc) ? 1'b0 : 1'b1;
            rst_m[c]  = dut_rst;
            a_m[c]    = A;
            b_m[c]    = B;
            done_m[c] = done;
            busy_m[c] = busy;
            if (done) begin
                pass_v  = pass;
                early_v = early;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        O_in  = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; order = '0; gap = '0; timeout = '0; O_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({dut_rst, A, B, busy, done, pass, early}), 32'h0);
        chk("reset_cnts", 32'({pass_cnt, fail_cnt}), 32'h0);
        reset = 1'b1;

        // Order AB, gap 3, O one cycle after B.
        run(2'b00, 3, 10, 7, 32'h1, -1, 12);
        chk("ab_rst",  rst_m, 32'h2);
        chk("ab_a",    a_m, 32'h4);
        chk("ab_b",    b_m, 32'h40);
        chk("ab_done", done_m, 32'h100);
        chk("ab_busy", busy_m, 32'h1FE);
        chk("ab_res",  32'({pass_v, early_v}), 32'h2);
        chk("ab_cnt",  32'({pass_cnt, fail_cnt}), 32'h4);   // pass=1 fail=0

        // Both together, O never arrives: timeout after 5 wait cycles.
        run(2'b10, 0, 5, -1, 32'h1, -1, 12);
        chk("both_a",    a_m, 32'h4);
        chk("both_b",    b_m, 32'h4);
        chk("both_done", done_m, 32'h100);
        chk("both_res",  32'({pass_v, early_v}), 32'h0);
        chk("both_cnt",  32'({pass_cnt, fail_cnt}), 32'h5); // pass=1 fail=1

        // A only, no O expected: pass after 4 wait cycles.
        run(2'b11, 0, 4, -1, 32'h1, -1, 12);
        chk("aonly_a",    a_m, 32'h4);
        chk("aonly_b",    b_m, 32'h0);
        chk("aonly_done", done_m, 32'h100);
        chk("aonly_res",  32'({pass_v, early_v}), 32'h2);
        chk("aonly_cnt",  32'({pass_cnt, fail_cnt}), 32'h9); // pass=2 fail=1

        // Order BA, gap 4, O during the gap: early fail, second pulse never sent.
        run(2'b01, 4, 10, 4, 32'h1, -1, 12);
        chk("early_b",    b_m, 32'h4);
        chk("early_a",    a_m, 32'h0);
        chk("early_done", done_m, 32'h20);
        chk("early_res",  32'({pass_v, early_v}), 32'h1);
        chk("early_cnt",  32'({pass_cnt, fail_cnt}), 32'hA); // pass=2 fail=2

        // O in the first-pulse cycle is also early.
        run(2'b00, 2, 10, 2, 32'h1, -1, 10);
        chk("early1_done", done_m, 32'h8);
        chk("early1_b",    b_m, 32'h0);
        chk("early1_res",  32'({pass_v, early_v}), 32'h1);
        chk("early1_cnt",  32'({pass_cnt, fail_cnt}), 32'hB); // pass=2 fail=3

        // Response in SECOND; extra starts while busy and in DONE are ignored.
        run(2'b00, 0, 3, 3, 32'h25, -1, 12);
        chk("busy_done", done_m, 32'h20);
        chk("busy_busy", busy_m, 32'h3E);
        chk("busy_res",  32'({pass_v, early_v}), 32'h2);
        chk("busy_cnt",  32'({pass_cnt, fail_cnt}), 32'hF); // pass=3 fail=3

        // Timeout 0 acts as 1; fail count stays saturated.
        run(2'b00, 0, 0, -1, 32'h1, -1, 10);
        chk("tmo0_done", done_m, 32'h20);
        chk("tmo0_res",  32'({pass_v, early_v}), 32'h0);
        chk("tmo0_cnt",  32'({pass_cnt, fail_cnt}), 32'hF);

        // Two more passing BA runs, gap 1: pass count saturates at 3.
        for (int k = 0; k < 2; k++) begin
            run(2'b01, 1, 2, 5, 32'h1, -1, 10);
            chk("ba_a",    a_m, 32'h10);
            chk("ba_b",    b_m, 32'h4);
            chk("ba_done", done_m, 32'h40);
            chk("ba_res",  32'({pass_v, early_v}), 32'h2);
        end
        chk("sat_cnt", 32'({pass_cnt, fail_cnt}), 32'hF);

        // A-only run where O shows up in the wait window: fail.
        run(2'b11, 0, 4, 5, 32'h1, -1, 10);
        chk("aonly_o_done", done_m, 32'h40);
        chk("aonly_o_res",  32'({pass_v, early_v}), 32'h0);

        // Reset in cycle 3 of a run aborts it and clears everything.
        run(2'b00, 3, 10, -1, 32'h1, 3, 14);
        chk("abort_busy", busy_m, 32'hE);
        chk("abort_done", done_m, 32'h0);
        chk("abort_b",    b_m, 32'h0);
        chk("abort_outs", 32'({dut_rst, A, B, busy, done, pass, early}), 32'h0);
        chk("abort_cnt",  32'({pass_cnt, fail_cnt}), 32'h0);

        // A fresh run after the abort works normally.
        run(2'b00, 0, 3, 4, 32'h1, -1, 10);
        chk("post_done", done_m, 32'h20);
        chk("post_cnt",  32'({pass_cnt, fail_cnt}), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
